// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: data width, NOP value and FSM encoding.
package fetch_stage_pkg;

  localparam int unsigned DataWidth = 32;

  typedef logic [DataWidth-1:0] word_t;

  localparam word_t Nop = 32'h0000_0000;

  // Fetch FSM encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StFull  = 2'd3;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that parks a fetched instruction while decode is stalled.
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  unload_i,
  input  logic  clear_i,
  input  word_t data_i,
  input  word_t pc_i,
  output word_t data_o,
  output word_t pc_o,
  output logic  valid_o
);

  word_t data_q, data_d;
  word_t pc_q, pc_d;
  logic  valid_q, valid_d;

  // Next-state: clear and unload win over load
  always_comb begin
    data_d  = data_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear_i || unload_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  // Entry storage with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= Nop;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory requester feeding the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rstd,
  input  logic [31:0] pc,
  input  logic        id_stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        pc_hold,
  output logic [31:0] fetch_count
);

  logic [1:0] state_q, state_d;
  word_t      req_pc_q, req_pc_d;
  logic       squash_q, squash_d;
  word_t      inst_out_q, inst_out_d;
  word_t      inst_pc_q, inst_pc_d;
  logic       inst_valid_q, inst_valid_d;
  word_t      fetch_count_q, fetch_count_d;

  logic  skid_load, skid_unload, skid_clear;
  word_t skid_data, skid_pc;
  logic  skid_valid;
  logic  grant;

  // Request is withheld during a flush so a wrong-path address is never granted
  always_comb begin
    imem_req  = (state_q == StIssue) && !flush;
    imem_addr = imem_req ? pc : '0;
    grant     = imem_req && imem_gnt;
    pc_hold   = !grant;
  end

  // FSM, IF/ID register and skid control
  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    squash_d      = squash_q;
    inst_out_d    = inst_out_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q && id_stall;
    fetch_count_d = fetch_count_q;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_clear    = 1'b0;

    unique case (state_q)
      StIdle: state_d = StIssue;
      StIssue: begin
        if (grant) begin
          req_pc_d = pc;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          squash_d = 1'b0;
          state_d  = StIssue;
          if (!flush && !squash_q) begin
            if (!id_stall || !inst_valid_q) begin
              inst_out_d    = imem_rdata;
              inst_pc_d     = req_pc_q;
              inst_valid_d  = 1'b1;
              fetch_count_d = fetch_count_q + 32'd1;
            end else begin
              skid_load = 1'b1;
              state_d   = StFull;
            end
          end
        end else if (flush) begin
          // Response still owed by memory; drop it when it shows up
          squash_d = 1'b1;
        end
      end
      StFull: begin
        if (flush) begin
          state_d = StIssue;
        end else if (!id_stall && skid_valid) begin
          inst_out_d    = skid_data;
          inst_pc_d     = skid_pc;
          inst_valid_d  = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
          skid_unload   = 1'b1;
          state_d       = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      inst_valid_d = 1'b0;
      skid_clear   = 1'b1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rstd) begin
      state_q       <= StIdle;
      req_pc_q      <= '0;
      squash_q      <= 1'b0;
      inst_out_q    <= Nop;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      squash_q      <= squash_d;
      inst_out_q    <= inst_out_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_skid u_skid (
    .clk_i    (clk),
    .rst_i    (rstd),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .data_i   (imem_rdata),
    .pc_i     (req_pc_q),
    .data_o   (skid_data),
    .pc_o     (skid_pc),
    .valid_o  (skid_valid)
  );

  assign inst_out    = inst_out_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign fetch_count = fetch_count_q;

endmodule
